// File: rtl/uart_rx_if.sv
// AXI-Stream byte channel carried out of the UART receiver.
// The master drives data/valid and the slave drives ready.
interface uart_rx_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rxd_i, deserialises LSB-first bytes and hands
// them out through a single-entry AXI-Stream holding register with error pulses.
module uart_rx #(
    parameter int unsigned CLK_FREQ = 160000000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          rxd_i,
    uart_rx_if.master     m_axis,
    output logic          frame_err_o,
    output logic          overrun_o,
    output logic          busy_o
);
    localparam int DIV  = int'(CLK_FREQ / BAUD);
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);

    localparam logic [CW-1:0] CNT_BIT  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    if (DIV < 4) begin : g_div_check
        $error("uart_rx: CLK_FREQ/BAUD must be at least 4");
    end

    logic          sync_a;
    logic          rx_s;
    logic          rx_hist;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shift;
    logic [7:0]    tdata;
    logic          tvalid;
    logic          frame_err;
    logic          overrun;
    logic          stop_now;
    logic          holding_free;

    // Two-flop synchroniser plus a history flop for start-edge detection
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_a  <= 1'b1;
            rx_s    <= 1'b1;
            rx_hist <= 1'b1;
        end else begin
            sync_a  <= rxd_i;
            rx_s    <= sync_a;
            rx_hist <= rx_s;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_hist && !rx_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        idx <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CNT_BIT) begin
                        shift[idx] <= rx_s;
                        cnt        <= '0;
                        if (idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    // Leaving STOP on the sample itself leaves half a bit to catch the next start edge
                    if (cnt == CNT_BIT) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign stop_now     = (state == STOP) && (cnt == CNT_BIT);
    assign holding_free = !tvalid || m_axis.tready;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tdata     <= '0;
            tvalid    <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (tvalid && m_axis.tready) begin
                tvalid <= 1'b0;
            end
            if (stop_now) begin
                if (!rx_s) begin
                    frame_err <= 1'b1;
                end else if (holding_free) begin
                    tdata  <= shift;
                    tvalid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

    assign m_axis.tdata  = tdata;
    assign m_axis.tvalid = tvalid;
    assign frame_err_o   = frame_err;
    assign overrun_o     = overrun;
    assign busy_o        = (state != IDLE);
endmodule
